block_mem_responder: RTL and testbench

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/block_mem_responder_pkg.sv | 45 ++++
 rtl/block_mem_responder_merge.sv | 38 +++
 rtl/block_mem_responder.sv | 141 ++++++++++++++
 tb/tb_block_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/block_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// block_mem_responder_pkg
// Shared memory-interface definitions used by the cache and by the block
// memory responder: request/response field positions and widths, write-width
// codes, the block data width, and the responder state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package block_mem_responder_pkg;

    localparam int BLOCK_DATA_WIDTH = 128;

    // Request bus layout: {DATA, WRITE_WIDTH, TYPE, VALID, ADDR}
    localparam int REQUEST_WIDTH    = 164;
    localparam int REQUEST_ADDR_LSB = 0;
    localparam int REQUEST_ADDR_MSB = 31;
    localparam int REQUEST_VALID    = 32;
    localparam int REQUEST_TYPE     = 33;
    localparam int REQUEST_WW_LSB   = 34;
    localparam int REQUEST_WW_MSB   = 35;
    localparam int REQUEST_DATA_LSB = 36;
    localparam int REQUEST_DATA_MSB = 163;

    // Response bus layout: {DATA, READY}
    localparam int RESPONSE_WIDTH    = 129;
    localparam int RESPONSE_READY    = 0;
    localparam int RESPONSE_DATA_LSB = 1;
    localparam int RESPONSE_DATA_MSB = 128;

    localparam logic REQ_TYPE_READ  = 1'b0;
    localparam logic REQ_TYPE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        WW_WORD  = 2'd0,
        WW_HALF  = 2'd1,
        WW_BYTE  = 2'd2,
        WW_WORD3 = 2'd3
    } write_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } resp_state_e;

endpackage

// File: rtl/block_mem_responder_merge.sv
// ----------------------------------------------------------------------------
// block_write_merge
// Combinational byte/half/word merge of write data into a 128-bit block.
// The write data is lane-aligned: the bytes taken from new_data are the ones
// sitting at the same bit positions they replace in the block.
// Ports:
//   old_blk  : current block contents
//   new_data : lane-aligned write data
//   offset   : byte offset inside the block (ADDR[3:0])
//   width    : write-width code (byte / half / word)
//   merged   : block with the selected lanes replaced
// ----------------------------------------------------------------------------
module block_write_merge
    import block_mem_responder_pkg::*;
(
    input  logic [BLOCK_DATA_WIDTH-1:0] old_blk,
    input  logic [BLOCK_DATA_WIDTH-1:0] new_data,
    input  logic [3:0]                  offset,
    input  logic [1:0]                  width,
    output logic [BLOCK_DATA_WIDTH-1:0] merged
);

    logic [BLOCK_DATA_WIDTH-1:0] lane_mask;
    logic [BLOCK_DATA_WIDTH-1:0] mask;

    always_comb begin
        case (write_width_e'(width))
            WW_BYTE: lane_mask = BLOCK_DATA_WIDTH'(16'h00FF);
            WW_HALF: lane_mask = BLOCK_DATA_WIDTH'(16'hFFFF);
            default: lane_mask = BLOCK_DATA_WIDTH'(32'hFFFF_FFFF);
        endcase
        // A left shift drops mask bits past bit 127, so an access that
        // straddles the block end is truncated instead of wrapping.
        mask   = lane_mask << {offset, 3'b000};
        merged = (old_blk & ~mask) | (new_data & mask);
    end

endmodule

// File: rtl/block_mem_responder.sv
// ----------------------------------------------------------------------------
// block_mem_responder
// Fixed-latency block memory model answering the cache lower-level port.
// A request is latched, held for LATENCY edges, then completed (read returns
// the block, write merges into it) and READY is held until the request
// changes or VALID drops.
// Ports:
//   CLK      : clock, rising edge
//   RST      : asynchronous active-low reset (memory contents untouched)
//   Request  : {DATA[163:36], WRITE_WIDTH[35:34], TYPE[33], VALID[32], ADDR[31:0]}
//   Response : {DATA[128:1], READY[0]}
// ----------------------------------------------------------------------------
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int LATENCY    = 64,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [REQUEST_WIDTH-1:0]  Request,
    output logic [RESPONSE_WIDTH-1:0] Response
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // LATENCY-1 always fits in clog2(LATENCY) bits.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    resp_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [REQUEST_WIDTH-1:0]    lreq_q, lreq_d;
    logic [RESPONSE_WIDTH-1:0]   resp_q, resp_d;
    logic                        mem_we;

    // No reset on the array: contents survive RST.
    logic [BLOCK_DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]       blk_idx;
    logic [BLOCK_DATA_WIDTH-1:0] mem_rdata;
    logic [BLOCK_DATA_WIDTH-1:0] merged;

    logic req_valid;
    logic req_match;

    assign req_valid = Request[REQUEST_VALID];
    assign req_match = (Request == lreq_q);

    // Upper address bits are ignored, so addresses alias onto the array.
    assign blk_idx   = lreq_q[DEPTH_LOG2+3:4];
    assign mem_rdata = mem[blk_idx];

    block_write_merge u_merge (
        .old_blk  (mem_rdata),
        .new_data (lreq_q[REQUEST_DATA_MSB:REQUEST_DATA_LSB]),
        .offset   (lreq_q[3:0]),
        .width    (lreq_q[REQUEST_WW_MSB:REQUEST_WW_LSB]),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lreq_d  = lreq_q;
        resp_d  = resp_q;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    lreq_d  = Request;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (!req_valid) begin
                    resp_d[RESPONSE_READY] = 1'b0;
                    state_d                = ST_IDLE;
                end else if (!req_match) begin
                    // Requester changed its mind: restart the wait.
                    lreq_d = Request;
                    cnt_d  = CNT_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (lreq_q[REQUEST_TYPE] == REQ_TYPE_WRITE) begin
                        mem_we = 1'b1;
                    end else begin
                        resp_d[RESPONSE_DATA_MSB:RESPONSE_DATA_LSB] = mem_rdata;
                    end
                    resp_d[RESPONSE_READY] = 1'b1;
                    state_d                = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!req_valid) begin
                    resp_d[RESPONSE_READY] = 1'b0;
                    state_d                = ST_IDLE;
                end else if (!req_match) begin
                    // New request with VALID still high (e.g. writeback
                    // followed directly by allocate).
                    resp_d[RESPONSE_READY] = 1'b0;
                    lreq_d                 = Request;
                    cnt_d                  = CNT_LOAD;
                    state_d                = ST_BUSY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lreq_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lreq_q  <= lreq_d;
            resp_q  <= resp_d;
        end
    end

    // Write is gated by RST so a write completing while reset is asserted
    // is dropped.
    always_ff @(posedge CLK) begin
        if (mem_we && RST) begin
            mem[blk_idx] <= merged;
        end
    end

    assign Response = resp_q;

endmodule

// File: tb/tb_block_mem_responder.sv
module tb_block_mem_responder;
    import block_mem_responder_pkg::*;

    localparam int LAT = 4;

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    logic [REQUEST_WIDTH-1:0]  Request = '0;
    logic [RESPONSE_WIDTH-1:0] Response;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    block_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Request  (Request),
        .Response (Response)
    );

    function automatic logic [REQUEST_WIDTH-1:0] mk_req(input logic [31:0] addr,
                                                        input logic wr,
                                                        input logic [1:0] ww,
                                                        input logic [127:0] data);
        return {data, ww, wr, 1'b1, addr};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request, waits for READY (bounded), returns the data and the
    // number of edges after the acceptance edge (-1 on timeout), then drops VALID.
    task automatic access(input logic [31:0] addr, input logic wr, input logic [1:0] ww,
                          input logic [127:0] data, output logic [127:0] rdata,
                          output int edges);
        Request = mk_req(addr, wr, ww, data);
        step();
        edges = 0;
        while (!Response[0] && edges < 20) begin
            step();
            edges++;
        end
        if (!Response[0]) edges = -1;
        rdata   = Response[128:1];
        Request = '0;
        step();
    endtask

    task automatic test_reset();
        #3 RST = 1'b0;
        #1;
        total++;
        if (Response !== '0) begin
            bad++;
            $display("FAIL reset_resp: got %h want 0", Response);
        end
        step();
        step();
        RST = 1'b1;
        step();
        step();
        step();
        total++;
        if (Response !== '0) begin
            bad++;
            $display("FAIL idle_resp: got %h want 0", Response);
        end
    endtask

    task automatic test_write_read();
        logic [127:0] rd;
        int           e;
        access(32'h14, 1'b1, WW_WORD, 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", e, LAT); end
        total++;
        if (rd !== 128'h0) begin bad++; $display("FAIL wr_data_kept: got %h want 0", rd); end
        total++;
        if (Response[0] !== 1'b0) begin bad++; $display("FAIL ready_clear: got %b want 0", Response[0]); end
        access(32'h10, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", e, LAT); end
        total++;
        if (rd !== 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000) begin
            bad++;
            $display("FAIL rd_data: got %h want 0000000000000000deadbeef00000000", rd);
        end
    endtask

    task automatic test_byte_merge();
        logic [127:0] rd;
        int           e;
        for (int i = 0; i < 4; i++) begin
            access(32'h20 + 32'(4 * i), 1'b1, WW_WORD, {128{1'b1}}, rd, e);
        end
        // Byte offset 5 -> bits 47:40, data lane-aligned.
        access(32'h25, 1'b1, WW_BYTE, 128'h0000_0000_0000_0000_0000_1200_0000_0000, rd, e);
        total++;
        if (rd !== 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000) begin
            bad++;
            $display("FAIL byte_wr_data_kept: got %h want 0000000000000000deadbeef00000000", rd);
        end
        access(32'h20, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL byte_rd_latency: got %0d want %0d", e, LAT); end
        total++;
        if (rd !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_12FF_FFFF_FFFF) begin
            bad++;
            $display("FAIL byte_merge: got %h want ffffffffffffffffffff12ffffffffff", rd);
        end
    endtask

    task automatic test_abort();
        logic [127:0] rd;
        int           e;
        logic         seen;
        seen    = 1'b0;
        Request = mk_req(32'h30, 1'b1, WW_WORD, {128{1'b1}});
        step();
        if (Response[0]) seen = 1'b1;
        step();
        if (Response[0]) seen = 1'b1;
        Request = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Response[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", seen); end
        access(32'h30, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL abort_rd_latency: got %0d want %0d", e, LAT); end
        total++;
        if (rd !== 128'h0) begin bad++; $display("FAIL abort_block3: got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        int n;
        Request = mk_req(32'h40, 1'b1, WW_WORD, 128'hCAFE_F00D);
        step();
        n = 0;
        while (!Response[0] && n < 20) begin step(); n++; end
        total++;
        if (n !== LAT) begin bad++; $display("FAIL b2b_wr_latency: got %0d want %0d", n, LAT); end
        step();
        total++;
        if (Response !== {128'h0, 1'b1}) begin
            bad++;
            $display("FAIL done_hold: got %h want %h", Response, {128'h0, 1'b1});
        end
        Request = mk_req(32'h40, 1'b0, WW_WORD, 128'h0);
        step();
        total++;
        if (Response[0] !== 1'b0) begin bad++; $display("FAIL b2b_fall: got %b want 0", Response[0]); end
        n = 0;
        while (!Response[0] && n < 20) begin step(); n++; end
        total++;
        if (n !== LAT) begin bad++; $display("FAIL b2b_rd_latency: got %0d want %0d", n, LAT); end
        total++;
        if (Response[128:1] !== 128'hCAFE_F00D) begin
            bad++;
            $display("FAIL b2b_data: got %h want cafef00d", Response[128:1]);
        end
        Request = '0;
        step();
    endtask

    task automatic test_boundary_alias();
        logic [127:0] rd;
        int           e;
        // Half at byte 15: only bits 127:120 land; the 0x11 filler is masked.
        access(32'h4F, 1'b1, WW_HALF, {8'hCD, {15{8'h11}}}, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL half_latency: got %0d want %0d", e, LAT); end
        access(32'h40, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (rd !== {8'hCD, 88'h0, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL half_boundary: got %h want %h", rd, {8'hCD, 88'h0, 32'hCAFE_F00D});
        end
        access(32'h104F, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (rd !== {8'hCD, 88'h0, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL alias_rd: got %h want %h", rd, {8'hCD, 88'h0, 32'hCAFE_F00D});
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] rd;
        int           e;
        Request = mk_req(32'h50, 1'b1, WW_WORD, {128{1'b1}});
        step();
        step();
        #3 RST = 1'b0;
        #1;
        total++;
        if (Response !== '0) begin bad++; $display("FAIL async_rst_resp: got %h want 0", Response); end
        Request = '0;
        step();
        step();
        RST = 1'b1;
        step();
        total++;
        if (Response !== '0) begin bad++; $display("FAIL post_rst_idle: got %h want 0", Response); end
        access(32'h50, 1'b0, WW_WORD, 128'h0, rd, e);
        total++;
        if (e !== LAT) begin bad++; $display("FAIL post_rst_latency: got %0d want %0d", e, LAT); end
        total++;
        if (rd !== 128'h0) begin bad++; $display("FAIL rst_block5: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_merge();
        test_abort();
        test_back_to_back();
        test_boundary_alias();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
